// File: rtl/fir_filter_stage_if.sv
// rtl/fir_filter_stage_if.sv - controller <-> FIR stage handshake and result bundle
interface fir_filter_stage_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  Filter_EN;
  logic [DATA_WIDTH-1:0] Filter_DIN;
  logic                  Filter_DVLD;
  logic                  Filter_DRDY;
  logic [DATA_WIDTH-1:0] Filter_DOUT;
  logic                  Filter_DNE;

  // Controller side: requests a run and supplies samples
  modport master (
    output Filter_EN, Filter_DIN, Filter_DVLD,
    input  Filter_DRDY, Filter_DOUT, Filter_DNE
  );

  // Filter side: accepts samples and returns the result
  modport slave (
    input  Filter_EN, Filter_DIN, Filter_DVLD,
    output Filter_DRDY, Filter_DOUT, Filter_DNE
  );
endinterface

// File: rtl/fir_filter_stage.sv
// rtl/fir_filter_stage.sv - sequential fixed-coefficient FIR stage (optional FILTER_SAT_EN output clamp)
module fir_filter_stage #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 4,
  parameter int COEF_FRAC  = 13,
  parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFFS = {4{16'h0800}}
) (
  input logic              Filter_CLK,
  input logic              Filter_RST_N,
  fir_filter_stage_if.slave bus
);

  localparam int PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam int AW    = PW + CNT_W;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic                          en_hist_q, en_hist_d;
  logic signed [DATA_WIDTH-1:0]  x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x_d [NUM_TAPS];
  logic signed [AW-1:0]          acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          drdy_q, drdy_d;
  logic [DATA_WIDTH-1:0]         dout_q, dout_d;
  logic                          dne_q, dne_d;

  logic signed [COEF_WIDTH-1:0]  coef [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [COEF_WIDTH-1:0]  c_sel;
  logic signed [PW-1:0]          prod;
  logic signed [AW-1:0]          scaled;
  logic [DATA_WIDTH-1:0]         result;
  logic                          xfer;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_coef
    assign coef[i] = COEFFS[i*COEF_WIDTH +: COEF_WIDTH];
  end

  // One tap per cycle: the tap counter picks both the sample and its coefficient.
  assign x_sel  = x_q[cnt_q];
  assign c_sel  = coef[cnt_q];
  assign prod   = $signed({{COEF_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel})
                * $signed({{DATA_WIDTH{c_sel[COEF_WIDTH-1]}}, c_sel});
  assign scaled = acc_q >>> COEF_FRAC;
  assign xfer   = bus.Filter_DVLD & drdy_q;

`ifdef FILTER_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp the scaled sum into the signed output range
  always_comb begin
    result = scaled[DATA_WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_scaled_hi;
  // Wrapping output: only the low result bits leave the block
  assign result           = scaled[DATA_WIDTH-1:0];
  assign unused_scaled_hi = ^scaled[AW-1:DATA_WIDTH];
`endif

  // Next-state and datapath updates for IDLE -> LOAD -> MAC -> OUT
  always_comb begin
    state_d   = state_q;
    en_hist_d = bus.Filter_EN;
    x_d       = x_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    drdy_d    = 1'b0;
    dout_d    = dout_q;
    dne_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only a fresh rising edge of EN starts a run, so a held EN never re-triggers.
        if (bus.Filter_EN && !en_hist_q) begin
          state_d = S_LOAD;
          acc_d   = '0;
          cnt_d   = '0;
          drdy_d  = 1'b1;
        end
      end

      S_LOAD: begin
        if (!bus.Filter_EN) begin
          state_d = S_IDLE;
        end else begin
          drdy_d = 1'b1;
          if (xfer) begin
            x_d[0] = $signed(bus.Filter_DIN);
            for (int i = 1; i < NUM_TAPS; i++) begin
              x_d[i] = x_q[i-1];
            end
            if (cnt_q == LAST_TAP) begin
              state_d = S_MAC;
              cnt_d   = '0;
              drdy_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      S_MAC: begin
        if (!bus.Filter_EN) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_q + {{CNT_W{prod[PW-1]}}, prod};
          if (cnt_q == LAST_TAP) begin
            state_d = S_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        // Result completes even if EN has already dropped.
        dout_d  = result;
        dne_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any partial run
  always_ff @(posedge Filter_CLK or negedge Filter_RST_N) begin
    if (!Filter_RST_N) begin
      state_q   <= S_IDLE;
      en_hist_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i] <= '0;
      end
      acc_q     <= '0;
      cnt_q     <= '0;
      drdy_q    <= 1'b0;
      dout_q    <= '0;
      dne_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_hist_q <= en_hist_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      drdy_q    <= drdy_d;
      dout_q    <= dout_d;
      dne_q     <= dne_d;
    end
  end

  assign bus.Filter_DRDY = drdy_q;
  assign bus.Filter_DOUT = dout_q;
  assign bus.Filter_DNE  = dne_q;

endmodule

// File: tb/tb_fir_filter_stage.sv
// tb/tb_fir_filter_stage.sv - self-checking bench for fir_filter_stage
module tb_fir_filter_stage;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam int CF = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic dvld = 1'b0;
  logic [DW-1:0] din = '0;
  bit cmp_on = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_filter_stage_if #(.DATA_WIDTH(DW)) bus0 ();
  fir_filter_stage_if #(.DATA_WIDTH(DW)) bus1 ();

  assign bus0.Filter_EN   = en;
  assign bus0.Filter_DIN  = din;
  assign bus0.Filter_DVLD = dvld;
  assign bus1.Filter_EN   = en;
  assign bus1.Filter_DIN  = din;
  assign bus1.Filter_DVLD = dvld;

  fir_filter_stage #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .COEF_FRAC(CF),
                     .COEFFS({4{16'h0800}})) u_dut0 (
    .Filter_CLK(clk), .Filter_RST_N(rst_n), .bus(bus0));

  fir_filter_stage #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .COEF_FRAC(CF),
                     .COEFFS({4{16'h7FFF}})) u_dut1 (
    .Filter_CLK(clk), .Filter_RST_N(rst_n), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint coef_of(int dut, int i);
    return (dut == 0) ? 64'sd2048 : 64'sd32767;
  endfunction

  function automatic logic [DW-1:0] filt(input longint xs[$], input int dut);
    longint acc;
    logic [63:0] r;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += xs[i] * coef_of(dut, i);
    acc = acc >>> CF;
`ifdef FILTER_SAT_EN
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
    r = acc;
    return r[DW-1:0];
  endfunction

  bit            m_collect = 1'b0;
  longint        m_q[$];
  int            m_cd = 0;
  logic          m_drdy = 1'b0;
  logic          m_dne = 1'b0;
  logic          m_hist = 1'b0;
  logic          m_xfer;
  logic [DW-1:0] m_dout [2] = '{24'h0, 24'h0};
  logic [DW-1:0] m_res [2] = '{24'h0, 24'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collect = 1'b0; m_q.delete(); m_cd = 0; m_drdy = 1'b0; m_dne = 1'b0;
      m_hist = 1'b0; m_dout[0] = '0; m_dout[1] = '0;
    end else begin
      m_xfer = dvld && m_drdy;
      m_dne = 1'b0;
      if (m_cd > 0) begin
        if (m_cd == 1) begin
          m_dout = m_res; m_dne = 1'b1; m_cd = 0;
        end else if (!en) m_cd = 0;
        else m_cd--;
      end else if (m_collect) begin
        if (!en) begin
          m_collect = 1'b0; m_drdy = 1'b0;
        end else if (m_xfer) begin
          m_q.push_front(longint'($signed(din)));
          if (m_q.size() == NT) begin
            m_res[0] = filt(m_q, 0);
            m_res[1] = filt(m_q, 1);
            m_collect = 1'b0; m_drdy = 1'b0; m_cd = NT + 1;
          end
        end
      end else if (en && !m_hist) begin
        m_collect = 1'b1; m_q.delete(); m_drdy = 1'b1;
      end
      m_hist = en;
    end
  end

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("drdy0", 32'(bus0.Filter_DRDY), 32'(m_drdy));
      chk("dne0",  32'(bus0.Filter_DNE),  32'(m_dne));
      chk("dout0", 32'(bus0.Filter_DOUT), 32'(m_dout[0]));
      chk("drdy1", 32'(bus1.Filter_DRDY), 32'(m_drdy));
      chk("dne1",  32'(bus1.Filter_DNE),  32'(m_dne));
      chk("dout1", 32'(bus1.Filter_DOUT), 32'(m_dout[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] s, input int gap);
    int guard;
    logic x;
    for (int g = 0; g < gap; g++) begin
      dvld = 1'b0; din = 24'($urandom); tick();
    end
    dvld = 1'b1; din = s;
    guard = 0;
    do begin
      x = bus0.Filter_DRDY;
      tick();
      guard++;
    end while (!x && guard < 50);
    if (!x) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_run();
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  task automatic wait_dne(output int n);
    n = 0;
    do begin
      tick(); n++;
    end while (!bus0.Filter_DNE && n < 40);
    if (n >= 40) chk("dne_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_basic();
    send(24'd100, 0); send(24'd200, 0); send(24'd300, 0); send(24'd400, 0);
  endtask

  int n;
  int cnt;
  bit abort_run;
  bit b2b;

  initial begin
    repeat (3) tick();
    chk("rst_drdy", 32'(bus0.Filter_DRDY), 32'd0);
    chk("rst_dne",  32'(bus0.Filter_DNE),  32'd0);
    chk("rst_dout", 32'(bus0.Filter_DOUT), 32'd0);
    cmp_on = 1'b1;
    rst_n = 1'b1;
    tick();

    // 1 basic
    start_run(); send_basic(); dvld = 1'b0;
    wait_dne(n);
    chk("t1_latency", 32'(n), 32'd5);
    chk("t1_dout", 32'(bus0.Filter_DOUT), 32'h0000FA);
    chk("t1_model", 32'(m_dout[0]), 32'h0000FA);
    tick();

    // 2 handshake with toggling DVLD, DVLD high in IDLE and MAC
    en = 1'b0; dvld = 1'b1; din = 24'd77; tick(); tick();
    en = 1'b1; tick();
    send(24'd100, 0); send(24'd200, 1); send(24'd300, 1); send(24'd400, 1);
    din = 24'd999;
    wait_dne(n);
    dvld = 1'b0;
    chk("t2_latency", 32'(n), 32'd5);
    chk("t2_dout", 32'(bus0.Filter_DOUT), 32'h0000FA);

    // 3 saturation / wrap with max coefficients
    start_run();
    repeat (4) send(24'h7FFFFF, 0);
    dvld = 1'b0;
    wait_dne(n);
`ifdef FILTER_SAT_EN
    chk("t3_dout1", 32'(bus1.Filter_DOUT), 32'h7FFFFF);
`else
    chk("t3_dout1", 32'(bus1.Filter_DOUT), 32'hFFEFF0);
`endif
    chk("t3_dout0", 32'(bus0.Filter_DOUT), 32'h7FFFFF);

    // 4 negative samples
    start_run();
    send(24'hFFFF9C, 0); send(24'hFFFF38, 0); send(24'hFFFED4, 0); send(24'hFFFE70, 0);
    dvld = 1'b0;
    wait_dne(n);
    chk("t4_dout", 32'(bus0.Filter_DOUT), 32'hFFFF06);
    chk("t4_model", 32'(m_dout[0]), 32'hFFFF06);

    // 5 abort after two samples
    start_run();
    send(24'd100, 0); send(24'd200, 0);
    en = 1'b0; dvld = 1'b0; tick();
    chk("t5_drdy", 32'(bus0.Filter_DRDY), 32'd0);
    cnt = 0;
    repeat (8) begin tick(); if (bus0.Filter_DNE) cnt++; end
    chk("t5_no_dne", 32'(cnt), 32'd0);
    chk("t5_dout_kept", 32'(bus0.Filter_DOUT), 32'hFFFF06);
    start_run(); send_basic(); dvld = 1'b0;
    wait_dne(n);
    chk("t5_rerun_dout", 32'(bus0.Filter_DOUT), 32'h0000FA);

    // 6 reset mid-MAC, then EN held high, then re-arm
    start_run();
    send(24'd11, 0); send(24'd22, 0); send(24'd33, 0); send(24'd44, 0);
    dvld = 1'b0; tick(); tick();
    rst_n = 1'b0; #1;
    chk("t6_rst_drdy", 32'(bus0.Filter_DRDY), 32'd0);
    chk("t6_rst_dne",  32'(bus0.Filter_DNE),  32'd0);
    chk("t6_rst_dout", 32'(bus0.Filter_DOUT), 32'd0);
    tick(); tick();
    en = 1'b0; rst_n = 1'b1; tick();
    en = 1'b1; tick();
    send_basic(); dvld = 1'b0;
    wait_dne(n);
    chk("t6_run1_dout", 32'(bus0.Filter_DOUT), 32'h0000FA);
    cnt = 0;
    repeat (20) begin
      dvld = 1'b1; din = 24'($urandom); tick();
      if (bus0.Filter_DNE) cnt++;
    end
    dvld = 1'b0;
    chk("t6_held_en_no_run", 32'(cnt), 32'd0);
    start_run();
    send(24'd400, 0); send(24'd300, 0); send(24'd200, 0); send(24'd100, 0);
    dvld = 1'b0;
    wait_dne(n);
    chk("t6_run2_latency", 32'(n), 32'd5);
    chk("t6_run2_dout", 32'(bus0.Filter_DOUT), 32'h0000FA);

    // randomized runs: gaps, aborts, back-to-back restarts
    start_run();
    for (int r = 0; r < 16; r++) begin
      abort_run = ($urandom_range(0, 3) == 0);
      b2b = 1'($urandom_range(0, 1));
      for (int k = 0; k < NT; k++) begin
        if (abort_run && k == 2) break;
        send(24'($urandom), $urandom_range(0, 2));
        dvld = 1'($urandom_range(0, 1));
      end
      if (abort_run) begin
        en = 1'b0; dvld = 1'b0; tick(); tick();
        en = 1'b1; tick();
      end else if (b2b) begin
        repeat (NT) tick();
        en = 1'b0; tick();
        en = 1'b1; dvld = 1'b0; tick();
      end else begin
        wait_dne(n);
        dvld = 1'b0;
        en = 1'b0; tick();
        en = 1'b1; tick();
      end
    end
    en = 1'b0; dvld = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
